regfile: RTL and testbench

//   General-purpose integer register file for the CPU datapath: 32 x 32-bit

---
 rtl/regfile.sv | 43 ++++
 tb/tb_regfile.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Integer register file: 32 x 32-bit, two combinational read ports and
// one synchronous write port. Register 0 reads as zero and ignores writes.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A write to r0 is dropped here, so r0 is never loaded with anything but zero.
  logic wr_go;
  assign wr_go = write_enable && (write_addr != '0);

  // Storage update: reset clears every entry and has priority over a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_go) begin
      regs[write_addr] <= write_data;
    end
  end

  // Combinational reads without write bypass. r0 is forced to zero here as
  // well, so it also reads zero before the first reset.
  always_comb begin
    read_data_a = (read_addr_a == '0) ? '0 : regs[read_addr_a];
    read_data_b = (read_addr_b == '0) ? '0 : regs[read_addr_b];
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the stimulus pushes expected read data,
// and a monitor pops and compares on the falling edge.
module tb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] read_addr_a = '0;
  logic [AW-1:0] read_addr_b = '0;
  logic [DW-1:0] read_data_a;
  logic [DW-1:0] read_data_b;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          write_enable = 1'b0;

  regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_addr_a  (read_addr_a),
    .read_addr_b  (read_addr_b),
    .read_data_a  (read_data_a),
    .read_data_b  (read_data_b),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    string         name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic sample_req = 1'b0;

  // Monitor: one sampled read per requested cycle, taken at the falling edge.
  always @(negedge clk) begin
    if (sample_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: sample requested with no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (read_data_a !== e.ea || read_data_b !== e.eb) begin
          errors++;
          $display("FAIL %s: got a=%h b=%h, expected a=%h b=%h",
                   e.name, read_data_a, read_data_b, e.ea, e.eb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    write_enable = 1'b1;
    write_addr   = AW'(a);
    write_data   = d;
    tick();
    write_enable = 1'b0;
  endtask

  // Presents read addresses for one cycle and queues the expected data.
  task automatic chk(input int ra, input int rb,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                     input string name);
    exp_t e;
    read_addr_a = AW'(ra);
    read_addr_b = AW'(rb);
    e.ea = ea;
    e.eb = eb;
    e.name = name;
    q.push_back(e);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [DW-1:0] v;
    v = 32'h9E37_79B9 * DW'(a) + 32'h0F0F_0001;
    return v;
  endfunction

  function automatic logic [DW-1:0] iso(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, 8'h5A, ~b, b};
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk(5, 31, 32'h0, 32'h0, "reset_init_5_31");
    chk(0, 1, 32'h0, 32'h0, "reset_init_0_1");

    // Written value is cleared by one reset edge
    do_write(5, 32'hDEAD_BEEF);
    chk(5, 31, 32'hDEAD_BEEF, 32'h0, "pre_reset_r5");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk(5, 31, 32'h0, 32'h0, "reset_clear_r5");

    // Reset has priority over a write in the same cycle
    rst = 1'b0;
    write_enable = 1'b1;
    write_addr = 5'd9;
    write_data = 32'hCAFE_F00D;
    tick();
    write_enable = 1'b0;
    rst = 1'b1;
    chk(9, 9, 32'h0, 32'h0, "reset_priority_r9");

    // Write/readback on port A, then port B
    for (int a = 1; a < 32; a++) begin
      do_write(a, pat(a));
      chk(a, 0, pat(a), 32'h0, $sformatf("wr_rd_a_r%0d", a));
    end
    for (int a = 1; a < 32; a++) begin
      do_write(a, ~pat(a));
      chk(0, a, 32'h0, ~pat(a), $sformatf("wr_rd_b_r%0d", a));
    end

    // r0 ignores writes
    do_write(0, 32'hFFFF_FFFF);
    chk(0, 0, 32'h0, 32'h0, "r0_zero");

    // Enable gating
    do_write(7, 32'hA5A5_A5A5);
    write_enable = 1'b0;
    write_addr = 5'd7;
    write_data = 32'h0000_1234;
    tick();
    tick();
    tick();
    chk(7, 7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "enable_gating_r7");

    // Dual port and no bypass
    do_write(3, 32'h11);
    do_write(4, 32'h22);
    chk(3, 4, 32'h11, 32'h22, "dual_port_3_4");
    write_enable = 1'b1;
    write_addr = 5'd3;
    write_data = 32'h33;
    chk(3, 3, 32'h11, 32'h11, "no_bypass_before_edge");
    write_enable = 1'b0;
    chk(3, 4, 32'h33, 32'h22, "after_edge_r3");

    // Isolation across all registers
    for (int a = 1; a < 32; a++) begin
      do_write(a, iso(a));
    end
    for (int a = 1; a < 32; a++) begin
      chk(a, 32 - a, iso(a), iso(32 - a), $sformatf("isolation_r%0d", a));
    end

    // Reset mid-sequence clears everything
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int a = 1; a < 32; a++) begin
      chk(a, 32 - a, 32'h0, 32'h0, $sformatf("mid_reset_r%0d", a));
    end

    tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
